// File: rtl/ysyx_23060332_pkg.sv
// rtl/ysyx_23060332_pkg.sv - shared constants and helpers for the GPR block
package ysyx_23060332_pkg;

  localparam int XLEN_DEF = 32;
  // Widest pending vector popcount() accepts; callers zero-extend into it.
  localparam int POP_W = 256;

  function automatic int REG_AW(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// rtl/ysyx_23060332_scoreboard.sv - pending-write bits and registered pending count
module ysyx_23060332_scoreboard
  import ysyx_23060332_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWR  = 1,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  output logic [NREG-1:0]   pend,
  output logic [AW:0]       pend_cnt
);

  localparam int CW = AW + 1;

  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;
  logic [AW:0]      pend_cnt_q;
  logic [AW:0]      pend_cnt_d;
  logic [POP_W-1:0] pend_ext;

  // Applied lowest priority first so later statements win: write clear, issue set, flush.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
        pend_d[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    pend_ext             = '0;
    pend_ext[NREG-1:0]   = pend_d;
    pend_cnt_d           = CW'(popcount(pend_ext));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/ysyx_23060332_regfile_mp.sv
// rtl/ysyx_23060332_regfile_mp.sv - multi-port GPR file with write bypass and pending scoreboard
module ysyx_23060332_regfile_mp
  import ysyx_23060332_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = REG_AW(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend;

  ysyx_23060332_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wen       (wen),
    .waddr     (waddr),
    .pend      (pend),
    .pend_cnt  (pend_cnt)
  );

  // Later ports overwrite earlier ones, so the highest index wins a same-address conflict.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
        regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] fwd;
    logic [XLEN-1:0] rd;
    logic            busy;

    assign ra = raddr[k*AW +: AW];

    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
          hit = 1'b1;
          fwd = wdata[j*XLEN +: XLEN];
        end
      end
    end

    // Reset and x0 both force a clean zero, independent of stored or forwarded data.
    always_comb begin
      rd   = '0;
      busy = 1'b0;
      if (!rst && (ra != '0)) begin
        if ((BYPASS != 0) && hit) begin
          rd = fwd;
        end else begin
          rd   = regs_q[ra];
          busy = pend[ra];
        end
      end
    end

    assign rdata[k*XLEN +: XLEN] = rd;
    assign rbusy[k]              = busy;
  end

endmodule

// File: tb/tb_ysyx_23060332_regfile_mp.sv
// tb/tb_ysyx_23060332_regfile_mp.sv - bench for the multi-port GPR file, bypass and non-bypass builds
module tb_ysyx_23060332_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                flush;

  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0]      rbusy_b, rbusy_n;
  logic [AW:0]         cnt_b, cnt_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  bit              m_valid = 1'b0;

  always #5 clk = ~clk;

  ysyx_23060332_regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wen(wen), .waddr(waddr),
    .wdata(wdata), .flush(flush), .pend_cnt(cnt_b)
  );

  ysyx_23060332_regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)
  ) dut_n (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .wen(wen), .waddr(waddr),
    .wdata(wdata), .flush(flush), .pend_cnt(cnt_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: register array, pending set, and the read rules.
  function automatic logic [XLEN-1:0] exp_rdata(input int k, input bit byp);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] r;
    bit              h;
    a = raddr[k*AW +: AW];
    r = '0;
    h = 1'b0;
    if (rst || a == 0) return '0;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && waddr[j*AW +: AW] == a) begin
        h = 1'b1;
        r = wdata[j*XLEN +: XLEN];
      end
    end
    if (byp && h) return r;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int k, input bit byp);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    if (rst || a == 0) return 1'b0;
    if (byp) begin
      for (int j = 0; j < NWR; j++) begin
        if (wen[j] && waddr[j*AW +: AW] == a) return 1'b0;
      end
    end
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int c;
    c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  always @(posedge clk) begin
    bit wr_hit;
    bit iss_hit;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int r = 1; r < NREG; r++) begin
        wr_hit = 1'b0;
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && waddr[j*AW +: AW] == AW'(r)) begin
            wr_hit    = 1'b1;
            m_regs[r] = wdata[j*XLEN +: XLEN];
          end
        end
        iss_hit = iss_valid && (iss_rd == AW'(r));
        if (flush)        m_pend[r] = 1'b0;
        else if (iss_hit) m_pend[r] = 1'b1;
        else if (wr_hit)  m_pend[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst || m_valid) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("byp.rdata%0d", k), 64'(rdata_b[k*XLEN +: XLEN]), 64'(exp_rdata(k, 1'b1)));
        check($sformatf("byp.rbusy%0d", k), 64'(rbusy_b[k]), 64'(exp_busy(k, 1'b1)));
        check($sformatf("nob.rdata%0d", k), 64'(rdata_n[k*XLEN +: XLEN]), 64'(exp_rdata(k, 1'b0)));
        check($sformatf("nob.rbusy%0d", k), 64'(rbusy_n[k]), 64'(exp_busy(k, 1'b0)));
      end
    end
    if (m_valid) begin
      check("byp.pend_cnt", 64'(cnt_b), 64'(exp_cnt()));
      check("nob.pend_cnt", 64'(cnt_n), 64'(exp_cnt()));
    end
  end

  task automatic idle();
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wen[p]                = 1'b1;
    waddr[p*AW +: AW]     = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  initial begin
    idle();
    raddr = '0;
    rst   = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    next();
    settle();
    check("reset pend_cnt", 64'(cnt_b), 64'd0);
    next();

    for (int r = 1; r < NREG; r++) begin
      wr(0, AW'(r), 32'hA5A5A5A5);
      next();
    end
    raddr = {5'd31, 5'd5};
    settle();
    check("load rd5", 64'(rdata_b[0 +: 32]), 64'hA5A5A5A5);
    check("load rd31 nob", 64'(rdata_n[32 +: 32]), 64'hA5A5A5A5);
    next();

    issue(5'd2);
    next();
    raddr = {5'd2, 5'd2};
    settle();
    check("pre-reset cnt", 64'(cnt_b), 64'd1);
    check("pre-reset busy", 64'(rbusy_b[0]), 64'd1);
    next();

    rst = 1'b1; wr(0, 5'd3, 32'h1); issue(5'd4); flush = 1'b1;
    next();
    for (int r = 0; r < 16; r++) begin
      raddr = {5'(r + 16), 5'(r)};
      settle();
      check("post-reset rdata0", 64'(rdata_b[0 +: 32]), 64'd0);
      check("post-reset rdata1", 64'(rdata_b[32 +: 32]), 64'd0);
      check("post-reset rbusy", 64'(rbusy_b), 64'd0);
      if (r == 0) check("post-reset cnt", 64'(cnt_b), 64'd0);
      next();
    end

    wr(0, 5'd0, 32'hFFFFFFFF); issue(5'd0); raddr = '0;
    settle();
    check("x0 same-cycle rdata", 64'(rdata_b[0 +: 32]), 64'd0);
    check("x0 same-cycle rbusy", 64'(rbusy_b[0]), 64'd0);
    next();
    settle();
    check("x0 rdata", 64'(rdata_b[0 +: 32]), 64'd0);
    check("x0 cnt", 64'(cnt_b), 64'd0);
    next();

    issue(5'd5); raddr = {5'd0, 5'd5};
    next();
    settle();
    check("bypass busy", 64'(rbusy_b[0]), 64'd1);
    check("bypass cnt", 64'(cnt_b), 64'd1);
    next();
    wr(0, 5'd5, 32'h1234);
    settle();
    check("bypass fwd data", 64'(rdata_b[0 +: 32]), 64'h1234);
    check("bypass fwd busy", 64'(rbusy_b[0]), 64'd0);
    check("nobypass old data", 64'(rdata_n[0 +: 32]), 64'd0);
    check("nobypass busy", 64'(rbusy_n[0]), 64'd1);
    next();
    settle();
    check("bypass cnt clear", 64'(cnt_b), 64'd0);
    check("nobypass new data", 64'(rdata_n[0 +: 32]), 64'h1234);
    next();

    wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2);
    next();
    raddr = {5'd0, 5'd7};
    settle();
    check("dual write byp", 64'(rdata_b[0 +: 32]), 64'h2);
    check("dual write nob", 64'(rdata_n[0 +: 32]), 64'h2);
    next();

    issue(5'd9); wr(0, 5'd9, 32'h55);
    next();
    raddr = {5'd9, 5'd0};
    settle();
    check("collide data", 64'(rdata_b[32 +: 32]), 64'h55);
    check("collide busy", 64'(rbusy_b[1]), 64'd1);
    check("collide cnt", 64'(cnt_b), 64'd1);
    next();
    wr(0, 5'd9, 32'h66);
    next();

    issue(5'd3); next();
    issue(5'd4); next();
    issue(5'd6); next();
    settle();
    check("flush pre cnt", 64'(cnt_b), 64'd3);
    next();
    flush = 1'b1; issue(5'd8); wr(1, 5'd10, 32'h77);
    next();
    raddr = {5'd10, 5'd8};
    settle();
    check("flush cnt", 64'(cnt_b), 64'd0);
    check("flush rbusy", 64'(rbusy_b), 64'd0);
    check("flush write", 64'(rdata_n[32 +: 32]), 64'h77);
    next();

    raddr = {5'd6, 5'd3};
    settle();
    check("flush rbusy old", 64'(rbusy_n), 64'd0);
    next();

    repeat (300) begin
      wen       = NWR'($urandom_range(0, 3));
      waddr     = NWR*AW'($urandom);
      wdata     = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      raddr     = NRD*AW'($urandom);
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
